// File: rtl/sumavimas_kanalai.sv
// Multi-channel time-interval summer: per-channel edge detect, signed fine/coarse combine,
// clamp, optional averaging, and a round-robin valid/ready output stream.
module sumavimas_kanalai #(
  parameter int KANALU        = 4,
  parameter int SIZE_FRONTU   = 8,
  parameter int SIZE_GRUBUS   = 8,
  parameter int SIZE_LAIKAS   = 16,
  parameter int KOEF          = 50,
  parameter int DAUGIKLIS     = 10,
  parameter int VIDURKIS_LOG2 = 0,
  localparam int KW = (KANALU > 1) ? $clog2(KANALU) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KANALU-1:0]             enable,
  input  logic [KANALU*SIZE_FRONTU-1:0] teigiamas_f,
  input  logic [KANALU*SIZE_FRONTU-1:0] neigiamas_f,
  input  logic [KANALU*SIZE_GRUBUS-1:0] grubus,
  output logic [SIZE_LAIKAS-1:0]        laikas,
  output logic [KW-1:0]                 kanalas,
  output logic                          prisotinta,
  output logic                          valid,
  input  logic                          ready,
  input  logic                          isvalyti,
  output logic [KANALU-1:0]             perpildymas
);

  localparam int AW = SIZE_LAIKAS + VIDURKIS_LOG2;
  localparam int CW = VIDURKIS_LOG2 + 1;
  localparam int TW = SIZE_GRUBUS + SIZE_FRONTU + 34;
  localparam logic [CW-1:0] CNT_FULL = CW'(2 ** VIDURKIS_LOG2);
  localparam logic [TW-1:0] LMAX = {{(TW-SIZE_LAIKAS){1'b0}}, {SIZE_LAIKAS{1'b1}}};

  logic [KANALU-1:0]      enable_d, ev;
  logic [KANALU-1:0]      c_v, s_v, s_sat, satacc, pend_v, pend_s;
  logic [SIZE_FRONTU-1:0] c_t [KANALU];
  logic [SIZE_FRONTU-1:0] c_n [KANALU];
  logic [SIZE_GRUBUS-1:0] c_g [KANALU];
  logic [SIZE_LAIKAS-1:0] s_val [KANALU];
  logic [AW-1:0]          acc [KANALU];
  logic [AW-1:0]          acc_sum [KANALU];
  logic [CW-1:0]          cnt [KANALU];
  logic [CW-1:0]          cnt_inc [KANALU];
  logic [SIZE_LAIKAS-1:0] pend_l [KANALU];
  logic [SIZE_LAIKAS-1:0] wr_l [KANALU];
  logic [KANALU-1:0]      done, wr_s, drain;

  logic [KW-1:0] rr_start, sel, arb_idx;
  logic          found, load;

  // Returns {sat, sample}; the intermediate is wide enough that no input combination wraps.
  function automatic logic [SIZE_LAIKAS:0] sample_of(input logic [SIZE_GRUBUS-1:0] g,
                                                     input logic [SIZE_FRONTU-1:0] tp,
                                                     input logic [SIZE_FRONTU-1:0] ng);
    logic signed [SIZE_FRONTU:0] d;
    logic signed [TW-1:0]        t;
    d = $signed({1'b0, tp}) - $signed({1'b0, ng});
    t = $signed({{(TW-SIZE_GRUBUS){1'b0}}, g}) * $signed(TW'(KOEF))
      + TW'(d) * $signed(TW'(DAUGIKLIS));
    if (t < 0)
      return {1'b1, {SIZE_LAIKAS{1'b0}}};
    else if (t > $signed(LMAX))
      return {1'b1, {SIZE_LAIKAS{1'b1}}};
    else
      return {1'b0, t[SIZE_LAIKAS-1:0]};
  endfunction

  assign ev   = enable & ~enable_d;
  assign load = ~valid | ready;

  always_comb begin
    for (int c = 0; c < KANALU; c++) begin
      acc_sum[c] = acc[c] + AW'(s_val[c]);
      cnt_inc[c] = cnt[c] + 1'b1;
      done[c]    = s_v[c] && (cnt_inc[c] == CNT_FULL);
      wr_l[c]    = SIZE_LAIKAS'(acc_sum[c] >> VIDURKIS_LOG2);
      wr_s[c]    = satacc[c] | s_sat[c];
    end
  end

  // Round-robin search begins at rr_start, which holds last winner + 1.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    arb_idx = '0;
    for (int i = 0; i < KANALU; i++) begin
      arb_idx = KW'((int'(rr_start) + i) % KANALU);
      if (!found && pend_v[arb_idx]) begin
        found = 1'b1;
        sel   = arb_idx;
      end
    end
    for (int c = 0; c < KANALU; c++)
      drain[c] = load && found && (sel == KW'(c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_d    <= enable;
      c_v         <= '0;
      s_v         <= '0;
      s_sat       <= '0;
      satacc      <= '0;
      pend_v      <= '0;
      pend_s      <= '0;
      perpildymas <= '0;
      valid       <= 1'b0;
      laikas      <= '0;
      kanalas     <= '0;
      prisotinta  <= 1'b0;
      rr_start    <= '0;
      for (int c = 0; c < KANALU; c++) begin
        c_t[c]    <= '0;
        c_n[c]    <= '0;
        c_g[c]    <= '0;
        s_val[c]  <= '0;
        acc[c]    <= '0;
        cnt[c]    <= '0;
        pend_l[c] <= '0;
      end
    end else begin
      enable_d <= enable;
      c_v      <= ev;
      s_v      <= c_v;
      for (int c = 0; c < KANALU; c++) begin
        if (ev[c]) begin
          c_t[c] <= teigiamas_f[c*SIZE_FRONTU +: SIZE_FRONTU];
          c_n[c] <= neigiamas_f[c*SIZE_FRONTU +: SIZE_FRONTU];
          c_g[c] <= grubus[c*SIZE_GRUBUS +: SIZE_GRUBUS];
        end
        if (c_v[c])
          {s_sat[c], s_val[c]} <= sample_of(c_g[c], c_t[c], c_n[c]);
        if (s_v[c]) begin
          if (done[c]) begin
            acc[c]    <= '0;
            satacc[c] <= 1'b0;
            cnt[c]    <= '0;
          end else begin
            acc[c]    <= acc_sum[c];
            satacc[c] <= wr_s[c];
            cnt[c]    <= cnt_inc[c];
          end
        end
        if (done[c]) begin
          pend_v[c] <= 1'b1;
          pend_l[c] <= wr_l[c];
          pend_s[c] <= wr_s[c];
        end else if (drain[c]) begin
          pend_v[c] <= 1'b0;
        end
        // Overflow set has priority over the clear pulse.
        if (done[c] && pend_v[c] && !drain[c])
          perpildymas[c] <= 1'b1;
        else if (isvalyti)
          perpildymas[c] <= 1'b0;
      end
      if (load) begin
        if (found) begin
          valid      <= 1'b1;
          laikas     <= pend_l[sel];
          prisotinta <= pend_s[sel];
          kanalas    <= sel;
          rr_start   <= (int'(sel) == KANALU - 1) ? '0 : sel + 1'b1;
        end else begin
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sumavimas_kanalai.sv
// Bench for sumavimas_kanalai: dut0 uses defaults, dut1 uses a 10-bit output with 4-sample averaging.
module tb_sumavimas_kanalai;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en0, en1;
  logic [31:0] tp0, ng0, gr0, tp1, ng1, gr1;
  logic        rdy0, rdy1, clr0, clr1;
  logic [15:0] l0;
  logic [9:0]  l1;
  logic [1:0]  k0, k1;
  logic        p0, p1, v0, v1;
  logic [3:0]  pf0, pf1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sumavimas_kanalai dut0 (
    .clk(clk), .rst(rst), .enable(en0), .teigiamas_f(tp0), .neigiamas_f(ng0), .grubus(gr0),
    .laikas(l0), .kanalas(k0), .prisotinta(p0), .valid(v0), .ready(rdy0),
    .isvalyti(clr0), .perpildymas(pf0)
  );

  sumavimas_kanalai #(.SIZE_LAIKAS(10), .DAUGIKLIS(1), .VIDURKIS_LOG2(2)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .teigiamas_f(tp1), .neigiamas_f(ng1), .grubus(gr1),
    .laikas(l1), .kanalas(k1), .prisotinta(p1), .valid(v1), .ready(rdy1),
    .isvalyti(clr1), .perpildymas(pf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: time = coarse*50 + (pos-neg)*weight, clamped to [0, 2^lw-1].
  function automatic int ref_sample(input int g, input int t, input int n, input int daug,
                                    input int lw, output bit sat);
    int v, mx;
    v   = g * 50 + (t - n) * daug;
    mx  = (1 << lw) - 1;
    sat = (v < 0) || (v > mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  task automatic set_codes(input int d, input int ch, input int g, input int t, input int n);
    if (d == 0) begin
      gr0[ch*8 +: 8] = 8'(g); tp0[ch*8 +: 8] = 8'(t); ng0[ch*8 +: 8] = 8'(n);
    end else begin
      gr1[ch*8 +: 8] = 8'(g); tp1[ch*8 +: 8] = 8'(t); ng1[ch*8 +: 8] = 8'(n);
    end
  endtask

  task automatic pulse(input int d, input int ch, input int g, input int t, input int n);
    set_codes(d, ch, g, t, n);
    if (d == 0) en0[ch] = 1'b1; else en1[ch] = 1'b1;
    tick();
    if (d == 0) en0[ch] = 1'b0; else en1[ch] = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input int d);
    int k = 0;
    while (((d == 0) ? v0 : v1) !== 1'b1 && k < 12) begin
      tick();
      k++;
    end
    chk("wait_valid", 32'((d == 0) ? v0 : v1), 1);
  endtask

  initial begin
    int  g, t, n, ch, e, sum, satc;
    bit  s;
    int  ev[4];
    bit  es[4];
    int  r[3];
    int  rg[3];

    rst = 1'b1;
    en0 = '0; en1 = '0;
    tp0 = '0; ng0 = '0; gr0 = '0; tp1 = '0; ng1 = '0; gr1 = '0;
    rdy0 = 1'b1; rdy1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_laikas", 32'(l0), 0);
    chk("rst_kanalas", 32'(k0), 0);
    chk("rst_prisotinta", 32'(p0), 0);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_perpildymas", 32'(pf0), 0);

    // Basic value and latency on ch0
    e = ref_sample(3, 7, 2, 10, 16, s);
    set_codes(0, 0, 3, 7, 2);
    en0[0] = 1'b1;
    tick();
    en0[0] = 1'b0;
    tick();
    tick();
    chk("lat_valid_early", 32'(v0), 0);
    tick();
    chk("lat_valid", 32'(v0), 1);
    chk("basic_laikas", 32'(l0), 32'(e));
    chk("basic_kanalas", 32'(k0), 0);
    chk("basic_prisotinta", 32'(p0), 32'(s));
    tick();
    chk("basic_valid_drop", 32'(v0), 0);

    // Negative clamp
    e = ref_sample(0, 1, 5, 10, 16, s);
    pulse(0, 0, 0, 1, 5);
    wait_valid(0);
    chk("neg_laikas", 32'(l0), 32'(e));
    chk("neg_prisotinta", 32'(p0), 32'(s));
    tick();

    // Random single-channel samples
    for (int i = 0; i < 20; i++) begin
      ch = int'($urandom_range(0, 3));
      g  = int'($urandom_range(0, 255));
      t  = int'($urandom_range(0, 255));
      n  = int'($urandom_range(0, 255));
      e  = ref_sample(g, t, n, 10, 16, s);
      pulse(0, ch, g, t, n);
      wait_valid(0);
      chk("rand_laikas", 32'(l0), 32'(e));
      chk("rand_kanalas", 32'(k0), 32'(ch));
      chk("rand_prisotinta", 32'(p0), 32'(s));
      tick();
    end

    // Round robin after a fresh reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      g = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 255));
      n = int'($urandom_range(0, 255));
      ev[c] = ref_sample(g, t, n, 10, 16, es[c]);
      set_codes(0, c, g, t, n);
    end
    en0 = 4'hF;
    tick();
    en0 = 4'h0;
    tick(); tick(); tick();
    for (int c = 0; c < 4; c++) begin
      chk("rr_kanalas", 32'(k0), 32'(c));
      chk("rr_laikas", 32'(l0), 32'(ev[c]));
      chk("rr_prisotinta", 32'(p0), 32'(es[c]));
      tick();
    end
    chk("rr_valid_drop", 32'(v0), 0);

    for (int c = 0; c < 4; c += 3) begin
      g = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 255));
      n = int'($urandom_range(0, 255));
      ev[c] = ref_sample(g, t, n, 10, 16, es[c]);
      set_codes(0, c, g, t, n);
    end
    en0 = 4'b1001;
    tick();
    en0 = 4'h0;
    tick(); tick(); tick();
    chk("rr2_first_kanalas", 32'(k0), 0);
    chk("rr2_first_laikas", 32'(l0), 32'(ev[0]));
    tick();
    chk("rr2_second_kanalas", 32'(k0), 3);
    chk("rr2_second_laikas", 32'(l0), 32'(ev[3]));
    tick();

    // Backpressure and overflow on ch1
    rdy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rg[i] = int'($urandom_range(1, 255));
      r[i]  = ref_sample(rg[i], 0, 0, 10, 16, s);
      pulse(0, 1, rg[i], 0, 0);
    end
    tick(); tick(); tick();
    chk("bp_valid", 32'(v0), 1);
    chk("bp_hold_r1", 32'(l0), 32'(r[0]));
    chk("bp_perpildymas", 32'(pf0), 32'h2);
    rdy0 = 1'b1;
    tick();
    chk("bp_next_r3", 32'(l0), 32'(r[2]));
    chk("bp_next_kanalas", 32'(k0), 1);
    chk("bp_next_valid", 32'(v0), 1);
    tick();
    chk("bp_valid_drop", 32'(v0), 0);
    chk("bp_perp_sticky", 32'(pf0), 32'h2);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("bp_perp_cleared", 32'(pf0), 0);

    // Averaging on dut1 ch2: 100,101,(102 held high),105
    sum = 0; satc = 0;
    sum += ref_sample(2, 0, 0, 1, 10, s); satc |= int'(s);
    pulse(1, 2, 2, 0, 0);
    sum += ref_sample(2, 1, 0, 1, 10, s); satc |= int'(s);
    pulse(1, 2, 2, 1, 0);
    sum += ref_sample(2, 2, 0, 1, 10, s); satc |= int'(s);
    set_codes(1, 2, 2, 2, 0);
    en1[2] = 1'b1;
    tick();
    set_codes(1, 2, 9, 0, 0);
    repeat (9) tick();
    en1[2] = 1'b0;
    tick();
    repeat (4) tick();
    chk("avg_no_early", 32'(v1), 0);
    sum += ref_sample(2, 5, 0, 1, 10, s); satc |= int'(s);
    pulse(1, 2, 2, 5, 0);
    wait_valid(1);
    chk("avg_laikas", 32'(l1), 32'(sum / 4));
    chk("avg_kanalas", 32'(k1), 2);
    chk("avg_prisotinta", 32'(p1), 32'(satc));
    tick();
    chk("avg_single_result", 32'(v1), 0);

    // High clamp on dut1 ch1
    sum = 0; satc = 0;
    for (int i = 0; i < 4; i++) begin
      t = int'($urandom_range(0, 255));
      n = int'($urandom_range(0, 255));
      sum += ref_sample(255, t, n, 1, 10, s); satc |= int'(s);
      pulse(1, 1, 255, t, n);
    end
    wait_valid(1);
    chk("hi_laikas", 32'(l1), 32'(sum / 4));
    chk("hi_prisotinta", 32'(p1), 32'(satc));
    chk("hi_kanalas", 32'(k1), 1);
    tick();

    // Reset mid-average with enable held high
    pulse(1, 0, 18, 0, 0);
    pulse(1, 0, 18, 0, 0);
    set_codes(1, 0, 18, 0, 0);
    en1[0] = 1'b1;
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("mid_rst_valid", 32'(v1), 0);
    chk("mid_rst_laikas", 32'(l1), 0);
    chk("mid_rst_kanalas", 32'(k1), 0);
    chk("mid_rst_prisotinta", 32'(p1), 0);
    chk("mid_rst_perp", 32'(pf1), 0);
    rst = 1'b0;
    tick(); tick();
    en1[0] = 1'b0;
    tick();
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      t = (i == 0) ? 0 : ((i == 1) ? 10 : 20);
      sum += ref_sample(4, t, 0, 1, 10, s);
      pulse(1, 0, 4, t, 0);
    end
    repeat (3) tick();
    chk("post_rst_no_early", 32'(v1), 0);
    sum += ref_sample(4, 31, 0, 1, 10, s);
    pulse(1, 0, 4, 31, 0);
    wait_valid(1);
    chk("post_rst_laikas", 32'(l1), 32'(sum / 4));
    chk("post_rst_kanalas", 32'(k1), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
